// File: rtl/uart_stream_decoder.sv
// rtl/uart_stream_decoder.sv - UART byte-stream command/escape decoder with pixel word packer
module uart_stream_decoder #(
  parameter logic [7:0] ESC_BYTE        = 8'hFE,
  parameter int         BYTES_PER_WORD  = 2,
  parameter int         BYTES_PER_FRAME = 786432,
  parameter int         CNT_W           = 26
) (
  input  logic                        iCLK,
  input  logic                        iRST_N,
  input  logic [7:0]                  iBYTE,
  input  logic                        iBYTE_VALID,
  output logic                        oBYTE_READY,
  output logic [8*BYTES_PER_WORD-1:0] oWORD,
  output logic                        oWORD_VALID,
  input  logic                        iWORD_READY,
  output logic [6:0]                  oNUM_IMAGES,
  output logic                        oTRIGGER,
  output logic                        oFRAME_DONE,
  output logic                        oBUSY,
  output logic                        oDONE,
  output logic                        oERROR,
  output logic [2:0]                  oERR_CODE
);

  localparam int               IDX_W     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] FRAME_LEN = CNT_W'(BYTES_PER_FRAME);

  typedef enum logic [2:0] {IDLE, LOAD_START, LOAD_DATA, DONE, ERROR} state_t;

  state_t                      state, state_next;
  logic                        esc_flag;
  logic [IDX_W-1:0]            idx;
  logic [8*BYTES_PER_WORD-1:0] part, word_fill;
  logic [CNT_W-1:0]            frame_cnt, total_cnt, target, total_inc, frame_inc, images_ext;
  logic                        accept, plain, esc_open, esc_abort, esc_ack, esc_lit, esc_bad, cmd_load;
  logic                        start_load, pixel, discard, code_we;
  logic [2:0]                  code_next;

  // A byte is blocked only while the trigger cycle runs or the output word slot is still occupied.
  assign oBYTE_READY = (state != LOAD_START) && (!oWORD_VALID || iWORD_READY);
  assign oTRIGGER    = (state == LOAD_START);
  assign oBUSY       = (state == LOAD_START) || (state == LOAD_DATA);
  assign oDONE       = (state == DONE);
  assign oERROR      = (state == ERROR);

  always_comb begin
    accept     = iBYTE_VALID && oBYTE_READY;
    plain      = accept && !esc_flag && (iBYTE != ESC_BYTE);
    esc_open   = accept && !esc_flag && (iBYTE == ESC_BYTE);
    esc_abort  = accept && esc_flag && (iBYTE == 8'h00);
    esc_ack    = accept && esc_flag && (iBYTE == 8'h01);
    esc_lit    = accept && esc_flag && (iBYTE == ESC_BYTE);
    esc_bad    = accept && esc_flag && !esc_abort && !esc_ack && !esc_lit;
    cmd_load   = plain && (iBYTE[7:6] == 2'b10);
    total_inc  = total_cnt + CNT_W'(1);
    frame_inc  = frame_cnt + CNT_W'(1);
    images_ext = CNT_W'(iBYTE[5:0]) + CNT_W'(1);
    word_fill  = part;
    word_fill[{idx, 3'b000} +: 8] = iBYTE;
  end

  always_comb begin
    state_next = state;
    code_we    = 1'b0;
    code_next  = oERR_CODE;
    start_load = 1'b0;
    pixel      = 1'b0;
    discard    = 1'b0;
    case (state)
      IDLE, ERROR: begin
        if (cmd_load) begin
          start_load = 1'b1;
          code_we    = 1'b1;
          code_next  = 3'd0;
          state_next = LOAD_START;
        end else if (plain || esc_lit) begin
          code_we    = 1'b1;
          code_next  = 3'd1;
          state_next = ERROR;
        end else if (esc_abort) begin
          code_we    = 1'b1;
          code_next  = 3'd0;
          state_next = IDLE;
        end else if (esc_bad) begin
          code_we    = 1'b1;
          code_next  = 3'd2;
          state_next = ERROR;
        end
      end
      LOAD_START: state_next = LOAD_DATA;
      LOAD_DATA: begin
        if (plain || esc_lit) begin
          pixel = 1'b1;
          if (total_inc == target) state_next = DONE;
        end else if (esc_abort) begin
          discard    = 1'b1;
          code_we    = 1'b1;
          code_next  = 3'd0;
          state_next = IDLE;
        end else if (esc_ack || esc_bad) begin
          discard    = 1'b1;
          code_we    = 1'b1;
          code_next  = 3'd2;
          state_next = ERROR;
        end
      end
      DONE: begin
        if (esc_abort) begin
          code_we    = 1'b1;
          code_next  = 3'd0;
          state_next = IDLE;
        end else if (esc_ack) begin
          state_next = IDLE;
        end else if (plain || esc_lit || esc_bad) begin
          code_we    = 1'b1;
          code_next  = 3'd3;
          state_next = ERROR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      esc_flag    <= 1'b0;
      idx         <= '0;
      part        <= '0;
      frame_cnt   <= '0;
      total_cnt   <= '0;
      target      <= '0;
      oWORD       <= '0;
      oWORD_VALID <= 1'b0;
      oNUM_IMAGES <= '0;
      oFRAME_DONE <= 1'b0;
      oERR_CODE   <= '0;
    end else begin
      oFRAME_DONE <= 1'b0;
      if (esc_open)                 esc_flag <= 1'b1;
      else if (accept && esc_flag)  esc_flag <= 1'b0;
      if (code_we)                  oERR_CODE <= code_next;
      if (oWORD_VALID && iWORD_READY) oWORD_VALID <= 1'b0;
      if (start_load) begin
        oNUM_IMAGES <= 7'(iBYTE[5:0]) + 7'd1;
        target      <= images_ext * FRAME_LEN;
        frame_cnt   <= '0;
        total_cnt   <= '0;
        idx         <= '0;
      end
      if (discard) idx <= '0;
      if (pixel) begin
        total_cnt <= total_inc;
        if (frame_inc == FRAME_LEN) begin
          frame_cnt   <= '0;
          oFRAME_DONE <= 1'b1;
        end else begin
          frame_cnt <= frame_inc;
        end
        // Slot is guaranteed free here: byte acceptance already required it.
        if (idx == LAST_IDX) begin
          oWORD       <= word_fill;
          oWORD_VALID <= 1'b1;
          idx         <= '0;
        end else begin
          part <= word_fill;
          idx  <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_stream_decoder.sv
// tb/tb_uart_stream_decoder.sv - scoreboard bench for uart_stream_decoder
module tb_uart_stream_decoder;
  localparam int BPW = 2;
  localparam int BPF = 4;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic [7:0]  iBYTE;
  logic        iBYTE_VALID;
  logic        oBYTE_READY;
  logic [15:0] oWORD;
  logic        oWORD_VALID;
  logic        iWORD_READY;
  logic [6:0]  oNUM_IMAGES;
  logic        oTRIGGER, oFRAME_DONE, oBUSY, oDONE, oERROR;
  logic [2:0]  oERR_CODE;

  int          checks = 0;
  int          failures = 0;
  int          trig_cnt = 0;
  int          fd_cnt = 0;
  logic [15:0] exp_q[$];

  uart_stream_decoder #(.ESC_BYTE(8'hFE), .BYTES_PER_WORD(BPW), .BYTES_PER_FRAME(BPF), .CNT_W(26)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iBYTE(iBYTE), .iBYTE_VALID(iBYTE_VALID), .oBYTE_READY(oBYTE_READY),
    .oWORD(oWORD), .oWORD_VALID(oWORD_VALID), .iWORD_READY(iWORD_READY), .oNUM_IMAGES(oNUM_IMAGES),
    .oTRIGGER(oTRIGGER), .oFRAME_DONE(oFRAME_DONE), .oBUSY(oBUSY), .oDONE(oDONE), .oERROR(oERROR),
    .oERR_CODE(oERR_CODE)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  initial begin : monitor
    logic        stall_prev;
    logic [15:0] word_prev;
    stall_prev = 1'b0;
    word_prev  = '0;
    forever begin
      @(negedge iCLK);
      if (oTRIGGER)    trig_cnt++;
      if (oFRAME_DONE) fd_cnt++;
      if (stall_prev && oWORD_VALID) chk("word_hold", oWORD, word_prev);
      if (oWORD_VALID && !iWORD_READY) chk("stall_ready", oBYTE_READY, 0);
      if (oWORD_VALID && iWORD_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL word_unexpected actual=%0h required=none", oWORD);
        end else begin
          chk("word", oWORD, exp_q.pop_front());
        end
      end
      stall_prev = oWORD_VALID && !iWORD_READY && iRST_N;
      word_prev  = oWORD;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    logic rdy;
    bit   done_flag;
    done_flag   = 1'b0;
    iBYTE       = b;
    iBYTE_VALID = 1'b1;
    for (int n = 0; n < 200 && !done_flag; n++) begin
      @(negedge iCLK);
      rdy = oBYTE_READY;
      @(posedge iCLK);
      #1;
      if (rdy) done_flag = 1'b1;
    end
    if (!done_flag) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=blocked required=accepted byte=%0h", b);
    end
    iBYTE_VALID = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b [8], input int n);
    for (int i = 0; i < n; i++) send(b[i]);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick(1);
    tick(2);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_busy"}, oBUSY, 0);
    chk({name, "_done"}, oDONE, 0);
    chk({name, "_error"}, oERROR, 0);
  endtask

  initial begin : stimulus
    int t0, f0;
    iRST_N      = 1'b0;
    iBYTE       = '0;
    iBYTE_VALID = 1'b0;
    iWORD_READY = 1'b1;
    tick(3);
    chk("rst_byte_ready", oBYTE_READY, 1);
    chk("rst_word_valid", oWORD_VALID, 0);
    chk("rst_word", oWORD, 0);
    chk("rst_num_images", oNUM_IMAGES, 0);
    chk("rst_err_code", oERR_CODE, 0);
    chk("rst_trigger", oTRIGGER, 0);
    chk("rst_frame_done", oFRAME_DONE, 0);
    check_idle("rst");
    iRST_N = 1'b1;
    tick(1);

    // Two-frame load, continuous drain.
    t0 = trig_cnt; f0 = fd_cnt;
    send(8'h81);
    chk("s1_num_images", oNUM_IMAGES, 2);
    chk("s1_busy", oBUSY, 1);
    exp_q.push_back(16'h2211); exp_q.push_back(16'h4433);
    exp_q.push_back(16'h6655); exp_q.push_back(16'h8877);
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 8);
    drain("s1_drain");
    chk("s1_done", oDONE, 1);
    chk("s1_triggers", trig_cnt - t0, 1);
    chk("s1_frame_dones", fd_cnt - f0, 2);
    send(8'hFE); send(8'h01);
    check_idle("s1_ack");

    // Literal escapes inside pixel data.
    f0 = fd_cnt;
    send(8'h80);
    chk("s2_num_images", oNUM_IMAGES, 1);
    exp_q.push_back(16'h01FE); exp_q.push_back(16'h02FE);
    send_bytes('{8'hFE, 8'hFE, 8'h01, 8'hFE, 8'hFE, 8'h02, 8'h00, 8'h00}, 6);
    drain("s2_drain");
    chk("s2_done", oDONE, 1);
    chk("s2_err_code", oERR_CODE, 0);
    chk("s2_frame_dones", fd_cnt - f0, 1);
    send(8'hFE); send(8'h01);
    check_idle("s2_ack");

    // Backpressure for ten cycles mid-load.
    t0 = trig_cnt; f0 = fd_cnt;
    send(8'h81);
    exp_q.push_back(16'h2211); exp_q.push_back(16'h4433);
    exp_q.push_back(16'h6655); exp_q.push_back(16'h8877);
    fork
      send_bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 8);
      begin
        for (int n = 0; n < 50 && !oWORD_VALID; n++) @(negedge iCLK);
        @(posedge iCLK);
        #1;
        iWORD_READY = 1'b0;
        repeat (10) @(posedge iCLK);
        #1;
        iWORD_READY = 1'b1;
      end
    join
    drain("s3_drain");
    chk("s3_done", oDONE, 1);
    chk("s3_triggers", trig_cnt - t0, 1);
    chk("s3_frame_dones", fd_cnt - f0, 2);
    send(8'hFE); send(8'h01);
    check_idle("s3_ack");

    // Error paths.
    send(8'h05);
    chk("s4_idle_err", oERROR, 1);
    chk("s4_idle_code", oERR_CODE, 1);
    send(8'hFE); send(8'h00);
    check_idle("s4_abort");
    chk("s4_abort_code", oERR_CODE, 0);
    send(8'h80);
    send(8'h11);
    send(8'hFE); send(8'h07);
    chk("s4_bad_esc_err", oERROR, 1);
    chk("s4_bad_esc_code", oERR_CODE, 2);
    chk("s4_bad_esc_busy", oBUSY, 0);
    send(8'hFE); send(8'h00);
    check_idle("s4_abort2");

    // Stray byte in DONE, then restart from ERROR.
    send(8'h80);
    exp_q.push_back(16'h2211); exp_q.push_back(16'h4433);
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    drain("s5_drain");
    chk("s5_done", oDONE, 1);
    send(8'h33);
    chk("s5_err", oERROR, 1);
    chk("s5_code", oERR_CODE, 3);
    send(8'h80);
    chk("s5_num_images", oNUM_IMAGES, 1);
    chk("s5_code_clr", oERR_CODE, 0);
    chk("s5_busy", oBUSY, 1);
    exp_q.push_back(16'h0605); exp_q.push_back(16'h0807);
    send_bytes('{8'h05, 8'h06, 8'h07, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    drain("s5_drain2");
    chk("s5_done2", oDONE, 1);
    send(8'hFE); send(8'h01);
    check_idle("s5_ack");

    // Asynchronous reset mid-word.
    send(8'h81);
    exp_q.push_back(16'h2211);
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    chk("s6_pre_busy", oBUSY, 1);
    #2;
    iRST_N = 1'b0;
    #1;
    chk("s6_rst_byte_ready", oBYTE_READY, 1);
    chk("s6_rst_word_valid", oWORD_VALID, 0);
    chk("s6_rst_word", oWORD, 0);
    chk("s6_rst_num_images", oNUM_IMAGES, 0);
    chk("s6_rst_err_code", oERR_CODE, 0);
    check_idle("s6_rst");
    tick(2);
    iRST_N = 1'b1;
    tick(1);
    send(8'h80);
    exp_q.push_back(16'hBBAA); exp_q.push_back(16'hDDCC);
    send_bytes('{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    drain("s6_drain");
    chk("s6_done", oDONE, 1);
    send(8'hFE); send(8'h01);
    check_idle("s6_ack");

    chk("final_queue", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
